// File: rtl/lsu_byte_serial_pkg.sv
// Shared types for the byte-serial load/store unit.
//   MemWidth : access width, same encoding as funct3[1:0]
//   LsuState : LSU sequencing states
//   lsu_len  : number of bytes N moved by an access of a given width
package lsu_byte_serial_pkg;

  typedef enum logic [1:0] {
    BITS8  = 2'd0,
    BITS16 = 2'd1,
    BITS32 = 2'd2
  } MemWidth;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_DRAIN,
    LSU_DONE
  } LsuState;

  function automatic logic [2:0] lsu_len(MemWidth w);
    case (w)
      BITS8:   return 3'd1;
      BITS16:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_serial_if.sv
// Request/response and byte-wide memory bus of the load/store unit.
//   master : control FSM + memory side (drives request and mem_rdata)
//   slave  : the LSU (drives status, rdata and the memory strobes)
// Signals:
//   start, is_store, funct3, addr, wdata : request
//   busy, done, err, rdata               : status / load result
//   mem_addr, mem_re, mem_we, mem_wdata  : memory command
//   mem_rdata                            : read byte, one cycle after mem_re
interface lsu_byte_serial_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              is_store;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    output start, is_store, funct3, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  start, is_store, funct3, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_byte_serial_load_extend.sv
// Combinational load assembly and extension.
// Inserts byte_in into lane byte_idx of buf_in, then sign- or zero-extends
// the assembled value according to width.
//   buf_in      in  32  partially assembled word
//   byte_in     in  8   byte to insert
//   byte_idx    in  2   lane for byte_in (0 = least significant)
//   width       in      access width
//   is_unsigned in  1   zero-extend when 1, sign-extend when 0
//   assembled   out 32  buf_in with byte_in inserted
//   rdata_next  out 32  extended result of assembled
module load_extend
  import lsu_byte_serial_pkg::*;
(
  input  logic [31:0] buf_in,
  input  logic [7:0]  byte_in,
  input  logic [1:0]  byte_idx,
  input  MemWidth     width,
  input  logic        is_unsigned,
  output logic [31:0] assembled,
  output logic [31:0] rdata_next
);

  logic fill8;
  logic fill16;

  always_comb begin
    assembled = buf_in;
    case (byte_idx)
      2'd0: assembled[7:0]   = byte_in;
      2'd1: assembled[15:8]  = byte_in;
      2'd2: assembled[23:16] = byte_in;
      default: assembled[31:24] = byte_in;
    endcase
  end

  always_comb begin
    fill8  = assembled[7]  & ~is_unsigned;
    fill16 = assembled[15] & ~is_unsigned;
    case (width)
      BITS8:   rdata_next = {{24{fill8}}, assembled[7:0]};
      BITS16:  rdata_next = {{16{fill16}}, assembled[15:0]};
      default: rdata_next = assembled;
    endcase
  end

endmodule

// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store unit serving the READ_MEMORY / WRITE_MEMORY states
// of the multicycle control FSM. One request is moved one byte per cycle
// over an 8-bit synchronous memory port, little-endian.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   bus    slave modport of lsu_byte_serial_if (request, status, memory)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// LSU_IDLE   | waiting for start; request validated here
// LSU_ACCESS | one byte per cycle, k = 0..N-1 (mem_we or mem_re)
// LSU_DRAIN  | load only: capture last byte, register extended rdata
// LSU_DONE   | one-cycle done pulse (err set if request was rejected)
module lsu_byte_serial
  import lsu_byte_serial_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int ADDR_W           = 32
) (
  input logic              clk,
  input logic              rst_n,
  lsu_byte_serial_if.slave bus
);

  LsuState           state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [31:0]       rdata_q;
  MemWidth           width_q;
  logic              unsigned_q;
  logic              store_q;
  logic              err_q;
  logic [2:0]        k_q;

  logic              req_bad;
  logic              misaligned;
  logic              bad_fn;
  logic [2:0]        last_k;
  logic              capture;
  logic [1:0]        byte_idx;
  logic [7:0]        wr_byte;
  logic [31:0]       assembled;
  logic [31:0]       rdata_next;

  // Request validation, evaluated only while idle.
  always_comb begin
    misaligned = ((bus.funct3[1:0] == 2'd1) && bus.addr[0]) ||
                 ((bus.funct3[1:0] == 2'd2) && (bus.addr[1:0] != 2'b00));
    if (bus.is_store)
      bad_fn = (bus.funct3 > 3'd2);
    else
      bad_fn = (bus.funct3[1:0] == 2'b11) || (bus.funct3 == 3'b110);
    req_bad = bad_fn || (!ALLOW_MISALIGNED && misaligned);
  end

  assign last_k = lsu_len(width_q) - 3'd1;

  // Read data lags mem_re by a cycle, so the byte arriving now belongs to
  // lane k-1; DRAIN (k = N) picks up the final lane.
  assign capture  = ((state_q == LSU_ACCESS) && !store_q && (k_q != 3'd0)) ||
                    (state_q == LSU_DRAIN);
  assign byte_idx = 2'(k_q - 3'd1);

  always_comb begin
    case (k_q[1:0])
      2'd0:    wr_byte = wdata_q[7:0];
      2'd1:    wr_byte = wdata_q[15:8];
      2'd2:    wr_byte = wdata_q[23:16];
      default: wr_byte = wdata_q[31:24];
    endcase
  end

  load_extend u_load_extend (
    .buf_in      (buf_q),
    .byte_in     (bus.mem_rdata),
    .byte_idx    (byte_idx),
    .width       (width_q),
    .is_unsigned (unsigned_q),
    .assembled   (assembled),
    .rdata_next  (rdata_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= LSU_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE:
        if (bus.start)
          state_d = req_bad ? LSU_DONE : LSU_ACCESS;
      LSU_ACCESS:
        if (k_q == last_k)
          state_d = store_q ? LSU_DONE : LSU_DRAIN;
      LSU_DRAIN:
        state_d = LSU_DONE;
      LSU_DONE:
        state_d = LSU_IDLE;
      default:
        state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 8'h00;
    case (state_q)
      LSU_ACCESS: begin
        bus.busy     = 1'b1;
        // Address wraps naturally at 2^ADDR_W.
        bus.mem_addr = base_q + ADDR_W'(k_q);
        bus.mem_we   = store_q;
        bus.mem_re   = !store_q;
        if (store_q)
          bus.mem_wdata = wr_byte;
      end
      LSU_DRAIN:
        bus.busy = 1'b1;
      LSU_DONE: begin
        bus.done = 1'b1;
        bus.err  = err_q;
      end
      default: ;
    endcase
  end

  assign bus.rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      rdata_q    <= '0;
      width_q    <= BITS8;
      unsigned_q <= 1'b0;
      store_q    <= 1'b0;
      err_q      <= 1'b0;
      k_q        <= '0;
    end else begin
      if ((state_q == LSU_IDLE) && bus.start) begin
        err_q <= req_bad;
        if (!req_bad) begin
          base_q     <= bus.addr;
          wdata_q    <= bus.wdata;
          width_q    <= MemWidth'(bus.funct3[1:0]);
          unsigned_q <= bus.funct3[2];
          store_q    <= bus.is_store;
          k_q        <= '0;
          buf_q      <= '0;
        end
      end
      if (state_q == LSU_ACCESS)
        k_q <= k_q + 3'd1;
      if (capture)
        buf_q <= assembled;
      if (state_q == LSU_DRAIN)
        rdata_q <= rdata_next;
    end
  end

endmodule

// File: tb/tb_lsu_byte_serial.sv
// Directed bench for lsu_byte_serial. u0 accepts misaligned accesses,
// u1 rejects them. Both share a 256-byte memory indexed by addr[7:0].
module tb_lsu_byte_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_byte_serial_if #(.ADDR_W(32)) b0 ();
  lsu_byte_serial_if #(.ADDR_W(32)) b1 ();

  lsu_byte_serial #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave)
  );
  lsu_byte_serial #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );

  logic [7:0]  mem [256] = '{default: 8'h00};
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h00;
  logic [7:0]  pl_data = 8'h00;
  logic [31:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic [31:0] rd_addr_q [$];
  int          acc1_cnt = 0;
  bit          both_seen = 1'b0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (b0.mem_we) begin
      mem[b0.mem_addr[7:0]] <= b0.mem_wdata;
      wr_addr_q.push_back(b0.mem_addr);
      wr_data_q.push_back(b0.mem_wdata);
    end
    if (b0.mem_re) begin
      rd_addr_q.push_back(b0.mem_addr);
      b0.mem_rdata <= mem[b0.mem_addr[7:0]];
    end else begin
      b0.mem_rdata <= 8'h00;
    end
    b1.mem_rdata <= b1.mem_re ? mem[b1.mem_addr[7:0]] : 8'h00;
    if (b1.mem_re || b1.mem_we) acc1_cnt <= acc1_cnt + 1;
    if ((b0.mem_re && b0.mem_we) || (b1.mem_re && b1.mem_we)) both_seen <= 1'b1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input bit s, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel == 0) begin
      b0.start = s; b0.is_store = st; b0.funct3 = f3; b0.addr = a; b0.wdata = wd;
    end else begin
      b1.start = s; b1.is_store = st; b1.funct3 = f3; b1.addr = a; b1.wdata = wd;
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel != 0) ? b1.done : b0.done;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel != 0) ? b1.rdata : b0.rdata;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel != 0) ? b1.err : b0.err;
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issues one request from an idle cycle; returns the cycle of done
  // (acceptance edge = cycle 0). Gives up after 20 cycles.
  task automatic req(input int sel, input bit st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, output int lat);
    @(posedge clk); #1;
    drive(sel, 1'b1, st, f3, a, wd);
    @(posedge clk); #1;
    drive(sel, 1'b0, st, f3, a, wd);
    lat = 1;
    while (!get_done(sel) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, n0, w0, acc, dn;
    drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(b0.busy), 32'd0);
    chk("rst_done", 32'(b0.done), 32'd0);
    chk("rst_err", 32'(b0.err), 32'd0);
    chk("rst_re_we", {30'd0, b0.mem_re, b0.mem_we}, 32'd0);
    chk("rst_rdata", b0.rdata, 32'h0);
    chk("rst_maddr", b0.mem_addr, 32'h0);
    chk("rst_mwdata", 32'(b0.mem_wdata), 32'h0);
    rst_n = 1'b1;

    poke(8'h80, 8'd88);
    poke(8'h10, 8'hF0);
    poke(8'h20, 8'h34);
    poke(8'h21, 8'h80);

    // LW at 0x80
    n0 = rd_addr_q.size();
    w0 = wr_addr_q.size();
    req(0, 1'b0, 3'b010, 32'h80, 32'h0, lat);
    chk("lw_lat", 32'(lat), 32'd6);
    chk("lw_rdata", get_rdata(0), 32'h0000_0058);
    chk("lw_err", 32'(get_err(0)), 32'd0);
    chk("lw_nrd", 32'(rd_addr_q.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++)
      if (n0 + i < rd_addr_q.size())
        chk("lw_raddr", rd_addr_q[n0 + i], 32'h80 + 32'(i));
    chk("lw_nwr", 32'(wr_addr_q.size() - w0), 32'd0);
    @(posedge clk); #1;
    chk("done_1cyc", 32'(b0.done), 32'd0);

    // byte / half loads
    req(0, 1'b0, 3'b000, 32'h10, 32'h0, lat);
    chk("lb_lat", 32'(lat), 32'd3);
    chk("lb_rdata", get_rdata(0), 32'hFFFF_FFF0);
    req(0, 1'b0, 3'b100, 32'h10, 32'h0, lat);
    chk("lbu_rdata", get_rdata(0), 32'h0000_00F0);
    req(0, 1'b0, 3'b001, 32'h20, 32'h0, lat);
    chk("lh_lat", 32'(lat), 32'd4);
    chk("lh_rdata", get_rdata(0), 32'hFFFF_8034);
    req(0, 1'b0, 3'b101, 32'h20, 32'h0, lat);
    chk("lhu_rdata", get_rdata(0), 32'h0000_8034);

    // SW across the address wrap
    n0 = rd_addr_q.size();
    w0 = wr_addr_q.size();
    req(0, 1'b1, 3'b010, 32'hFFFF_FFFE, 32'hDEAD_BEEF, lat);
    chk("sw_lat", 32'(lat), 32'd5);
    chk("sw_nwr", 32'(wr_addr_q.size() - w0), 32'd4);
    chk("sw_nrd", 32'(rd_addr_q.size() - n0), 32'd0);
    if (wr_addr_q.size() >= w0 + 4) begin
      chk("sw_a0", wr_addr_q[w0],     32'hFFFF_FFFE);
      chk("sw_a1", wr_addr_q[w0 + 1], 32'hFFFF_FFFF);
      chk("sw_a2", wr_addr_q[w0 + 2], 32'h0000_0000);
      chk("sw_a3", wr_addr_q[w0 + 3], 32'h0000_0001);
      chk("sw_d0", 32'(wr_data_q[w0]),     32'hEF);
      chk("sw_d1", 32'(wr_data_q[w0 + 1]), 32'hBE);
      chk("sw_d2", 32'(wr_data_q[w0 + 2]), 32'hAD);
      chk("sw_d3", 32'(wr_data_q[w0 + 3]), 32'hDE);
    end
    chk("sw_rdata_kept", get_rdata(0), 32'h0000_8034);
    req(0, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, lat);
    chk("lw_wrap_rdata", get_rdata(0), 32'hDEAD_BEEF);

    // invalid store width on u0
    w0 = wr_addr_q.size();
    req(0, 1'b1, 3'b100, 32'h40, 32'h1234, lat);
    chk("bad_st_lat", 32'(lat), 32'd1);
    chk("bad_st_err", 32'(get_err(0)), 32'd1);
    chk("bad_st_nwr", 32'(wr_addr_q.size() - w0), 32'd0);

    // aligned-only instance
    req(1, 1'b0, 3'b010, 32'h80, 32'h0, lat);
    chk("u1_lw_lat", 32'(lat), 32'd6);
    chk("u1_lw_rdata", get_rdata(1), 32'h0000_0058);
    acc = acc1_cnt;
    req(1, 1'b0, 3'b010, 32'h81, 32'h0, lat);
    chk("u1_mis_lat", 32'(lat), 32'd1);
    chk("u1_mis_err", 32'(get_err(1)), 32'd1);
    chk("u1_mis_rdata", get_rdata(1), 32'h0000_0058);
    req(1, 1'b0, 3'b011, 32'h80, 32'h0, lat);
    chk("u1_f3_err", 32'(get_err(1)), 32'd1);
    chk("u1_f3_lat", 32'(lat), 32'd1);
    req(1, 1'b1, 3'b001, 32'h21, 32'h0, lat);
    chk("u1_sh_mis_err", 32'(get_err(1)), 32'd1);
    @(posedge clk); #1;
    chk("u1_no_access", 32'(acc1_cnt - acc), 32'd0);

    // start held high across two SBs
    @(posedge clk); #1;
    w0 = wr_addr_q.size();
    dn = 0;
    drive(0, 1'b1, 1'b1, 3'b000, 32'h40, 32'h11);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (b0.done) dn++;
      if (i == 0) drive(0, 1'b1, 1'b1, 3'b000, 32'h41, 32'h22);
      if (i == 3) drive(0, 1'b0, 1'b1, 3'b000, 32'h41, 32'h22);
      @(posedge clk);
    end
    #1;
    chk("b2b_done_cnt", 32'(dn), 32'd2);
    chk("b2b_nwr", 32'(wr_addr_q.size() - w0), 32'd2);
    if (wr_addr_q.size() >= w0 + 2) begin
      chk("b2b_a0", wr_addr_q[w0], 32'h40);
      chk("b2b_d0", 32'(wr_data_q[w0]), 32'h11);
      chk("b2b_a1", wr_addr_q[w0 + 1], 32'h41);
      chk("b2b_d1", 32'(wr_data_q[w0 + 1]), 32'h22);
    end

    // reset during the second ACCESS cycle of an SW
    w0 = wr_addr_q.size();
    drive(0, 1'b1, 1'b1, 3'b010, 32'h60, 32'h4433_2211);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 3'b010, 32'h60, 32'h4433_2211);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", 32'(b0.busy), 32'd0);
    chk("mid_rst_strobes", {29'd0, b0.done, b0.mem_re, b0.mem_we}, 32'd0);
    chk("mid_rst_maddr", b0.mem_addr, 32'h0);
    chk("mid_rst_rdata", b0.rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_nwr", 32'(wr_addr_q.size() - w0), 32'd2);
    if (wr_addr_q.size() >= w0 + 2) begin
      chk("mid_rst_a1", wr_addr_q[w0 + 1], 32'h61);
      chk("mid_rst_d1", 32'(wr_data_q[w0 + 1]), 32'h22);
    end
    req(0, 1'b0, 3'b010, 32'h80, 32'h0, lat);
    chk("post_rst_lat", 32'(lat), 32'd6);
    chk("post_rst_rdata", get_rdata(0), 32'h0000_0058);

    chk("re_we_exclusive", 32'(both_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
